// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: eight-requester round-robin arbiter that captures the
// winning lane's data into a single valid/ready output register.
// A grant latches data, source index and one-hot grant; they stay frozen
// until the downstream handshake, which returns the FSM to IDLE, pulses
// ack for the completed requester and advances the priority pointer.
module mux8_rr_sched #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] data_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_src,
    output logic [2:0]      sel,
    output logic [7:0]      grant,
    output logic [7:0]      ack,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      sel_q, sel_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      grant_q, grant_d;
    logic [7:0]      ack_q, ack_d;

    logic            win_vld;
    logic [2:0]      win_idx;
    logic [2:0]      scan_idx;
    logic            hs;

    // Round-robin search: scan from the farthest offset down to ptr so the
    // closest set request (lowest offset from ptr) is the last one written.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            scan_idx = ptr_q + 3'(i);
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Handshake only exists while a captured transfer is being offered.
    always_comb begin
        hs = (state_q == SEND) && out_ready;
    end

    // Next-state logic: IDLE arbitrates, SEND waits for the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = SEND;
            SEND:    if (hs)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on grant, release and ack on handshake.
    // Everything holds otherwise; ack is a single-cycle pulse.
    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        grant_d = grant_q;
        ack_d   = 8'd0;
        if (state_q == IDLE && win_vld) begin
            sel_d   = win_idx;
            grant_d = 8'd1 << win_idx;
            data_d  = data_in[win_idx*DW +: DW];
        end
        if (hs) begin
            grant_d = 8'd0;
            ack_d   = 8'd1 << sel_q;
            ptr_d   = sel_q + 3'd1;
        end
    end

    // State register with synchronous reset; reset drops any pending
    // transfer without acknowledging it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            data_q  <= '0;
            grant_q <= 8'd0;
            ack_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
        end
    end

    // Output decode: valid and busy are both just "in SEND".
    always_comb begin
        out_valid = (state_q == SEND);
        busy      = (state_q == SEND);
        out_data  = data_q;
        out_src   = sel_q;
        sel       = sel_q;
        grant     = grant_q;
        ack       = ack_q;
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched: hand-computed expectations per step.
module tb_mux8_rr_sched;

    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [7:0]      req;
    logic [8*DW-1:0] data_in;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_src;
    logic [2:0]      sel;
    logic [7:0]      grant;
    logic [7:0]      ack;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    mux8_rr_sched #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs and samples both land 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        data_in[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        data_in = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) set_lane(i, 8'(8'h10 + i));

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_src",   32'(out_src),   32'd0);
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_grant", 32'(grant),     32'd0);
        chk("rst_ack",   32'(ack),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);

        // Idle with out_ready high and no requests: nothing happens
        out_ready = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ack",   32'(ack),       32'd0);

        // Single requester lane 3
        set_lane(3, 8'hA5);
        req = 8'h08;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data),  32'hA5);
        chk("single_src",   32'(out_src),   32'd3);
        chk("single_sel",   32'(sel),       32'd3);
        chk("single_grant", 32'(grant),     32'h08);
        chk("single_busy",  32'(busy),      32'd1);
        chk("single_noack", 32'(ack),       32'd0);
        req = 8'h00;
        tick();
        chk("single_ack",     32'(ack),       32'h08);
        chk("single_vld0",    32'(out_valid), 32'd0);
        chk("single_gnt0",    32'(grant),     32'h00);
        chk("single_holddat", 32'(out_data),  32'hA5);
        tick();
        chk("single_ackpulse", 32'(ack), 32'h00);
        // ptr now 4: requests on 3 and 4 must pick 4
        req = 8'h18;
        tick();
        chk("ptr4_src", 32'(out_src), 32'd4);
        req = 8'h00;
        tick();
        chk("ptr4_ack", 32'(ack), 32'h10);

        // All requesting from reset: 0..7,0 with a bubble between grants
        do_reset();
        set_lane(3, 8'h13);
        req = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("all_vld%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("all_src%0d", k), 32'(out_src), 32'(k % 8));
            chk($sformatf("all_dat%0d", k), 32'(out_data), 32'(8'h10 + (k % 8)));
            tick();
            chk($sformatf("all_bub%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("all_ack%0d", k), 32'(ack), 32'(8'd1 << (k % 8)));
        end

        // Backpressure on lane 5 while its data and req move
        do_reset();
        set_lane(5, 8'h5C);
        req = 8'h20;
        out_ready = 1'b0;
        tick();
        chk("bp_src0", 32'(out_src), 32'd5);
        for (int k = 0; k < 4; k++) begin
            set_lane(5, 8'(8'hE0 + k));
            req = (k % 2 == 0) ? 8'h00 : 8'hDF;
            tick();
            chk($sformatf("bp_dat%0d", k),   32'(out_data),  32'h5C);
            chk($sformatf("bp_src%0d", k),   32'(out_src),   32'd5);
            chk($sformatf("bp_gnt%0d", k),   32'(grant),     32'h20);
            chk($sformatf("bp_vld%0d", k),   32'(out_valid), 32'd1);
            chk($sformatf("bp_noack%0d", k), 32'(ack),       32'h00);
        end
        req = 8'h00;
        out_ready = 1'b1;
        tick();
        chk("bp_ack",  32'(ack),       32'h20);
        chk("bp_vld0", 32'(out_valid), 32'd0);
        tick();
        chk("bp_ack1", 32'(ack), 32'h00);

        // Wrap: get ptr to 7, then req 0x81 -> 7 then 0
        do_reset();
        req = 8'h40;
        out_ready = 1'b1;
        tick();
        chk("wrap_pre", 32'(out_src), 32'd6);
        req = 8'h81;
        tick();
        tick();
        chk("wrap_w7", 32'(out_src), 32'd7);
        tick();
        chk("wrap_ack7", 32'(ack), 32'h80);
        tick();
        chk("wrap_w0", 32'(out_src), 32'd0);

        // Priority skip: ptr=2, req=0x03 -> 0, then 1
        do_reset();
        req = 8'h02;
        out_ready = 1'b1;
        tick();
        chk("skip_pre", 32'(out_src), 32'd1);
        req = 8'h03;
        tick();
        tick();
        chk("skip_w0", 32'(out_src), 32'd0);
        tick();
        tick();
        chk("skip_w1", 32'(out_src), 32'd1);
        req = 8'h0C;
        tick();
        // ptr=2 -> lane 2 wins
        tick();
        chk("mid_pre", 32'(out_src), 32'd2);

        // Reset mid-SEND: abandon, no ack, ptr back to 0
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_vld",   32'(out_valid), 32'd0);
        chk("mid_data",  32'(out_data),  32'd0);
        chk("mid_src",   32'(out_src),   32'd0);
        chk("mid_grant", 32'(grant),     32'h00);
        chk("mid_ack",   32'(ack),       32'h00);
        chk("mid_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        req = 8'h06;
        tick();
        chk("mid_ack2",  32'(ack),     32'h00);
        chk("mid_ptr0",  32'(out_src), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
